// File: rtl/tiny_nn_feeder_pkg.sv
// Shared types and constants for the tiny_nn byte-to-word feeder.
package tiny_nn_feeder_pkg;

  // Session states of the feeder.
  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_FILL   = 2'd1,
    FEED_STREAM = 2'd2
  } feed_state_e;

  // Word driven downstream whenever no real FIFO word is presented.
  localparam logic [15:0] IDLE_WORD_DEFAULT = 16'h0000;

  // The first byte of each pair is the low half of the word.
  localparam bit LOW_BYTE_FIRST = 1'b1;

  // Combine two bytes, in arrival order, into one 16-bit word.
  function automatic logic [15:0] assemble_word(input logic [7:0] first_byte,
                                                input logic [7:0] second_byte);
    return LOW_BYTE_FIRST ? {second_byte, first_byte} : {first_byte, second_byte};
  endfunction

endpackage

// File: rtl/tiny_nn_sync_fifo.sv
// Single-clock FIFO with explicit occupancy counter so full and empty
// are distinguishable while pointers wrap modulo DEPTH.
module tiny_nn_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_reg == DEPTH_L);
  assign empty    = (level_reg == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];
  assign level    = level_reg;

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; clear flushes like reset.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/tiny_nn_word_feeder.sv
// Byte-to-word feeder for tiny_nn_top: pairs bytes into words, buffers
// them, then streams one word per cycle once the buffer has filled.
module tiny_nn_word_feeder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IDLE_WORD  = tiny_nn_feeder_pkg::IDLE_WORD_DEFAULT
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              stop_i,
  input  logic [7:0]                        byte_i,
  input  logic                              byte_valid_i,
  output logic                              byte_ready_o,
  output logic [15:0]                       data_o,
  output logic                              word_strobe_o,
  output logic                              underrun_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o
);

  import tiny_nn_feeder_pkg::*;

  feed_state_e state_reg;
  logic        pending_reg;
  logic [7:0]  low_reg;
  logic [15:0] data_reg;
  logic        strobe_reg;
  logic        underrun_reg;

  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] fifo_head;
  logic        session_stop;
  logic        byte_accept;
  logic        push;
  logic        pop;
  logic [15:0] push_word;

  // Readiness ignores a same-cycle pop, so a completed pair always has room.
  assign byte_ready_o = !pending_reg || !fifo_full;
  assign byte_accept  = byte_valid_i && byte_ready_o;
  // stop only has meaning inside a session; in IDLE it is a no-op.
  assign session_stop = stop_i && (state_reg != FEED_IDLE);
  assign push         = byte_accept && pending_reg && !session_stop;
  assign pop          = (state_reg == FEED_STREAM) && !fifo_empty && !session_stop;
  assign push_word    = assemble_word(low_reg, byte_i);

  tiny_nn_sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .srst      (rst_i),
    .clear     (session_stop),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

  // Half-word holding register: first byte of a pair waits here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_reg <= 1'b0;
      low_reg     <= 8'h00;
    end else if (session_stop) begin
      pending_reg <= 1'b0;
    end else if (byte_accept) begin
      if (!pending_reg) begin
        low_reg     <= byte_i;
        pending_reg <= 1'b1;
      end else begin
        pending_reg <= 1'b0;
      end
    end
  end

  // Session state machine with registered word/strobe/underrun outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= FEED_IDLE;
      data_reg     <= IDLE_WORD;
      strobe_reg   <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      data_reg   <= IDLE_WORD;
      strobe_reg <= 1'b0;
      case (state_reg)
        FEED_IDLE: begin
          if (start_i) begin
            state_reg    <= FEED_FILL;
            underrun_reg <= 1'b0;
          end
        end
        FEED_FILL: begin
          if (stop_i) begin
            state_reg <= FEED_IDLE;
          end else if (fifo_full) begin
            state_reg <= FEED_STREAM;
          end
        end
        FEED_STREAM: begin
          if (stop_i) begin
            state_reg <= FEED_IDLE;
          end else if (pop) begin
            data_reg   <= fifo_head;
            strobe_reg <= 1'b1;
          end else begin
            underrun_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= FEED_IDLE;
        end
      endcase
    end
  end

  assign data_o        = data_reg;
  assign word_strobe_o = strobe_reg;
  assign underrun_o    = underrun_reg;

endmodule

// File: tb/tb_tiny_nn_word_feeder.sv
// Self-checking bench for tiny_nn_word_feeder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_tiny_nn_word_feeder;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [15:0] IDLE_W = 16'h0000;
  localparam int M_IDLE = 0, M_FILL = 1, M_STREAM = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, stop_i, byte_valid_i;
  logic [7:0]    byte_i;
  logic          byte_ready_o, word_strobe_o, underrun_o;
  logic [15:0]   data_o;
  logic [LW-1:0] level_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: word queue, half-word holder, session mode.
  logic [15:0] m_q[$];
  bit          m_pend;
  logic [7:0]  m_low;
  int          m_mode;
  bit          m_under;
  logic [15:0] m_data;
  bit          m_strobe;

  tiny_nn_word_feeder #(.FIFO_DEPTH(DEPTH), .IDLE_WORD(IDLE_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_ready_o  (byte_ready_o),
    .data_o        (data_o),
    .word_strobe_o (word_strobe_o),
    .underrun_o    (underrun_o),
    .level_o       (level_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_update(input bit rst, input bit st, input bit sp,
                              input bit bv, input logic [7:0] b);
    int pre;
    bit acc;
    pre = m_q.size();
    acc = bv && (!m_pend || (pre < DEPTH));
    m_data   = IDLE_W;
    m_strobe = 0;
    if (rst) begin
      m_q.delete();
      m_pend  = 0;
      m_mode  = M_IDLE;
      m_under = 0;
    end else if (sp && m_mode != M_IDLE) begin
      m_q.delete();
      m_pend = 0;
      m_mode = M_IDLE;
    end else begin
      if (m_mode == M_STREAM) begin
        if (pre > 0) begin
          m_data   = m_q.pop_front();
          m_strobe = 1;
        end else begin
          m_under = 1;
        end
      end else if (m_mode == M_FILL) begin
        if (pre == DEPTH) m_mode = M_STREAM;
      end else if (st) begin
        m_mode  = M_FILL;
        m_under = 0;
      end
      if (acc) begin
        if (m_pend) begin
          m_q.push_back({b, m_low});
          m_pend = 0;
        end else begin
          m_low  = b;
          m_pend = 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle.
  task automatic step(input bit rst, input bit st, input bit sp,
                      input bit bv, input logic [7:0] b);
    rst_i = rst; start_i = st; stop_i = sp; byte_valid_i = bv; byte_i = b;
    @(posedge clk_i);
    model_update(rst, st, sp, bv, b);
    #1;
    rst_i = 0; start_i = 0; stop_i = 0; byte_valid_i = 0;
  endtask

  // From IDLE: start, feed 8 bytes (byte k = v[8k+:8]), wait for STREAM.
  task automatic load_session(input logic [63:0] v);
    step(0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, v[8*k +: 8]);
    step(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    checks++; if (data_o !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_o); end
    checks++; if (word_strobe_o !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", word_strobe_o); end
    checks++; if (underrun_o !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun_o); end
    checks++; if (level_o !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (byte_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", byte_ready_o); end
  endtask

  task automatic test_fill_stream();
    logic [63:0] v = 64'hDEF0_9ABC_5678_1234;
    step(0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 1, v[8*k +: 8]);
      checks++;
      if (level_o !== LW'((k + 1) / 2) || word_strobe_o !== 1'b0) begin
        failures++; $display("FAIL fill_level byte=%0d level=%0d strobe=%b exp_level=%0d exp_strobe=0", k, level_o, word_strobe_o, (k + 1) / 2);
      end
    end
    step(0, 0, 0, 0, 8'h00);
    checks++; if (word_strobe_o !== 1'b0 || level_o !== LW'(4)) begin failures++; $display("FAIL fill_to_stream strobe=%b level=%0d exp 0/4", word_strobe_o, level_o); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 8'h00);
      $display("fill_stream word %0d data=%h strobe=%b", i, data_o, word_strobe_o);
      checks++;
      if (data_o !== v[16*i +: 16] || word_strobe_o !== 1'b1) begin
        failures++; $display("FAIL stream_word idx=%0d got=%h/%b exp=%h/1", i, data_o, word_strobe_o, v[16*i +: 16]);
      end
    end
  endtask

  task automatic test_underrun();
    step(0, 0, 0, 0, 8'h00);
    checks++; if (data_o !== 16'h0000 || word_strobe_o !== 1'b0 || underrun_o !== 1'b1) begin
      failures++; $display("FAIL underrun_set data=%h strobe=%b under=%b exp 0000/0/1", data_o, word_strobe_o, underrun_o); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 8'h00);
      checks++; if (underrun_o !== 1'b1) begin failures++; $display("FAIL underrun_hold cyc=%0d got=%b exp=1", i, underrun_o); end
    end
    step(0, 0, 1, 0, 8'h00);
    checks++; if (underrun_o !== 1'b1 || level_o !== '0) begin failures++; $display("FAIL underrun_after_stop under=%b level=%0d exp 1/0", underrun_o, level_o); end
    step(0, 1, 0, 0, 8'h00);
    checks++; if (underrun_o !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%b exp=0", underrun_o); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_w[5] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h2211};
    bit pend22 = 1;
    bit drive, acc;
    int n = 0;
    step(0, 0, 1, 0, 8'h00);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 8'(k + 1));
    step(0, 0, 0, 1, 8'h11);
    checks++; if (byte_ready_o !== 1'b0 || level_o !== LW'(4)) begin failures++; $display("FAIL bp_ready ready=%b level=%0d exp 0/4", byte_ready_o, level_o); end
    for (int c = 0; c < 12; c++) begin
      drive = pend22;
      acc   = drive && byte_ready_o;
      step(0, c == 0, 0, drive, 8'h22);
      if (acc) pend22 = 0;
      if (word_strobe_o === 1'b1) begin
        $display("backpressure word %0d data=%h", n, data_o);
        checks++;
        if (n >= 5) begin failures++; $display("FAIL bp_extra_word got=%h exp=none", data_o); end
        else if (data_o !== exp_w[n]) begin failures++; $display("FAIL bp_word idx=%0d got=%h exp=%h", n, data_o, exp_w[n]); end
        if (n == 0) begin
          checks++; if (byte_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", byte_ready_o); end
        end
        n++;
      end
    end
    checks++; if (n != 5) begin failures++; $display("FAIL bp_word_count got=%0d exp=5", n); end
  endtask

  task automatic test_stop();
    logic [63:0] v1 = 64'h8877_6655_4433_2211;
    logic [63:0] v2 = 64'h0F1E_2D3C_4B5A_6978;
    step(0, 0, 1, 0, 8'h00);
    load_session(v1);
    step(0, 0, 0, 1, 8'hAA);
    checks++; if (data_o !== v1[15:0] || word_strobe_o !== 1'b1) begin failures++; $display("FAIL stop_pre_word0 got=%h exp=%h", data_o, v1[15:0]); end
    step(0, 0, 0, 0, 8'h00);
    checks++; if (level_o !== LW'(2)) begin failures++; $display("FAIL stop_pre_level got=%0d exp=2", level_o); end
    step(0, 0, 1, 1, 8'hBB);
    checks++; if (level_o !== '0 || data_o !== 16'h0000 || word_strobe_o !== 1'b0 || byte_ready_o !== 1'b1) begin
      failures++; $display("FAIL stop_flush level=%0d data=%h strobe=%b ready=%b exp 0/0000/0/1", level_o, data_o, word_strobe_o, byte_ready_o); end
    load_session(v2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 8'h00);
      $display("after_stop word %0d data=%h", i, data_o);
      checks++; if (data_o !== v2[16*i +: 16] || word_strobe_o !== 1'b1) begin
        failures++; $display("FAIL stop_new_word idx=%0d got=%h/%b exp=%h/1", i, data_o, word_strobe_o, v2[16*i +: 16]); end
    end
    step(0, 0, 0, 0, 8'h00);
    checks++; if (word_strobe_o !== 1'b0) begin failures++; $display("FAIL stop_no_stale got=%b data=%h exp strobe 0", word_strobe_o, data_o); end
  endtask

  task automatic test_reset_mid_stream();
    logic [63:0] v3 = 64'hA1B2_C3D4_E5F6_0718;
    logic [63:0] v4 = 64'h1357_9BDF_2468_ACE0;
    step(0, 0, 1, 0, 8'h00);
    load_session(v3);
    step(0, 0, 0, 0, 8'h00);
    checks++; if (level_o !== LW'(3)) begin failures++; $display("FAIL rstmid_level got=%0d exp=3", level_o); end
    step(1, 0, 0, 0, 8'h00);
    checks++; if (data_o !== 16'h0000 || word_strobe_o !== 1'b0 || underrun_o !== 1'b0 || level_o !== '0 || byte_ready_o !== 1'b1) begin
      failures++; $display("FAIL rstmid_outputs data=%h strobe=%b under=%b level=%0d ready=%b exp 0000/0/0/0/1", data_o, word_strobe_o, underrun_o, level_o, byte_ready_o); end
    load_session(v4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 8'h00);
      checks++; if (data_o !== v4[16*i +: 16] || word_strobe_o !== 1'b1) begin
        failures++; $display("FAIL rstmid_new_word idx=%0d got=%h/%b exp=%h/1", i, data_o, word_strobe_o, v4[16*i +: 16]); end
    end
    step(0, 0, 0, 0, 8'h00);
    checks++; if (word_strobe_o !== 1'b0) begin failures++; $display("FAIL rstmid_no_stale got=%b data=%h exp strobe 0", word_strobe_o, data_o); end
  endtask

  task automatic test_random();
    bit exp_rdy;
    int words = 0;
    step(1, 0, 0, 0, 8'h00);
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7, 8'($urandom));
      exp_rdy = !m_pend || (m_q.size() < DEPTH);
      if (m_strobe) words++;
      checks++; if (data_o !== m_data) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, data_o, m_data); end
      checks++; if (word_strobe_o !== m_strobe) begin failures++; $display("FAIL rand_strobe cyc=%0d got=%b exp=%b", c, word_strobe_o, m_strobe); end
      checks++; if (underrun_o !== m_under) begin failures++; $display("FAIL rand_underrun cyc=%0d got=%b exp=%b", c, underrun_o, m_under); end
      checks++; if (level_o !== LW'(m_q.size())) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", c, level_o, m_q.size()); end
      checks++; if (byte_ready_o !== exp_rdy) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, byte_ready_o, exp_rdy); end
    end
    $display("random run streamed %0d words", words);
  endtask

  initial begin
    rst_i = 0; start_i = 0; stop_i = 0; byte_valid_i = 0; byte_i = 8'h00;
    m_pend = 0; m_low = 8'h00; m_mode = M_IDLE; m_under = 0; m_data = IDLE_W; m_strobe = 0;
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    test_fill_stream();
    test_underrun();
    test_backpressure();
    test_stop();
    test_reset_mid_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
